step_move_ctrl: RTL and testbench

//  Sequences one shared PulseGen instance to execute a stepper move of arbitrary length.

---
 rtl/step_move_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_step_move_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_move_ctrl.sv
// step_move_ctrl
//   Runs one stepper move of arbitrary length on a single shared PulseGen.
//   A move command sets the DIR pin, waits a direction-setup interval counted
//   in en ticks when the direction actually changes, then feeds PulseGen with
//   bursts no longer than 2^PULSE_NUM_BITS-1 pulses until the move is done
//   or an abort request lets the burst in flight finish.
//
// Ports
//   clk            system clock
//   reset          asynchronous reset, active low
//   en             FreqDivider tick, the same one PulseGen uses
//   start          move command strobe, accepted only when idle
//   steps          total pulses requested for the move
//   dir            requested direction
//   pulse_width    pulse width handed to PulseGen for every burst
//   abort          stop after the burst in flight
//   pg_done        PulseGen idle/finished flag
//   pg_pulse_num   burst length to PulseGen
//   pg_pulse_width latched pulse width to PulseGen
//   pg_trigger     PulseGen trigger, held until PulseGen reports busy
//   dir_out        DIR pin to the driver
//   busy           high from accepted start through the done strobe
//   done           one-cycle strobe at the end of a move
//   steps_done     pulses completed in the current or last move
//
// state | meaning
// IDLE  | waiting for start; abort flag cleared
// SETUP | DIR changed, counting down en ticks before the first trigger
// ISSUE | trigger held with the burst length until PulseGen goes busy
// RUN   | burst in flight, waiting for PulseGen to finish
// FIN   | done strobe, busy drops on exit
module step_move_ctrl #(
    parameter int STEPS_BITS       = 16,
    parameter int PULSE_NUM_BITS   = 8,
    parameter int PULSE_WIDTH_BITS = 8,
    parameter int DIR_SETUP_TICKS  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        start,
    input  logic [STEPS_BITS-1:0]       steps,
    input  logic                        dir,
    input  logic [PULSE_WIDTH_BITS-1:0] pulse_width,
    input  logic                        abort,
    input  logic                        pg_done,
    output logic [PULSE_NUM_BITS-1:0]   pg_pulse_num,
    output logic [PULSE_WIDTH_BITS-1:0] pg_pulse_width,
    output logic                        pg_trigger,
    output logic                        dir_out,
    output logic                        busy,
    output logic                        done,
    output logic [STEPS_BITS-1:0]       steps_done
);

    localparam int SETUP_W = $clog2(DIR_SETUP_TICKS + 1);
    localparam logic [STEPS_BITS-1:0] MAX_CHUNK =
        STEPS_BITS'((64'd1 << PULSE_NUM_BITS) - 64'd1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ISSUE = 3'd2,
        RUN   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [STEPS_BITS-1:0]       remaining_q, remaining_d;
    logic [STEPS_BITS-1:0]       steps_done_q, steps_done_d;
    logic [PULSE_NUM_BITS-1:0]   pulse_num_q, pulse_num_d;
    logic [PULSE_WIDTH_BITS-1:0] pulse_width_q, pulse_width_d;
    logic [SETUP_W-1:0]          setup_cnt_q, setup_cnt_d;
    logic                        trigger_q, trigger_d;
    logic                        dir_q, dir_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        abort_q, abort_d;
    logic                        abort_now;

    function automatic logic [PULSE_NUM_BITS-1:0] chunk_of(input logic [STEPS_BITS-1:0] rem);
        if (rem > MAX_CHUNK) begin
            return PULSE_NUM_BITS'(MAX_CHUNK);
        end
        return PULSE_NUM_BITS'(rem);
    endfunction

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        steps_done_d  = steps_done_q;
        pulse_num_d   = pulse_num_q;
        pulse_width_d = pulse_width_q;
        setup_cnt_d   = setup_cnt_q;
        dir_d         = dir_q;
        busy_d        = busy_q;
        // abort is only recorded while a move is in progress
        abort_d       = abort_q | (busy_q & abort);
        abort_now     = abort_q | abort;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    remaining_d   = steps;
                    pulse_width_d = pulse_width;
                    steps_done_d  = '0;
                    busy_d        = 1'b1;
                    if (steps == '0) begin
                        state_d = FIN;
                    end else if (dir == dir_q) begin
                        state_d = ISSUE;
                    end else begin
                        dir_d       = dir;
                        setup_cnt_d = SETUP_W'(DIR_SETUP_TICKS);
                        state_d     = SETUP;
                    end
                end
            end
            SETUP: begin
                if (abort_now) begin
                    state_d = FIN;
                end else if (en) begin
                    setup_cnt_d = setup_cnt_q - SETUP_W'(1);
                    if (setup_cnt_q == SETUP_W'(1)) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // PulseGen dropping done is its acknowledgement of the trigger
                if (!pg_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pg_done) begin
                    remaining_d  = remaining_q - STEPS_BITS'(pulse_num_q);
                    steps_done_d = steps_done_q + STEPS_BITS'(pulse_num_q);
                    if ((remaining_d == '0) || abort_now) begin
                        state_d = FIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // burst length is fixed on entry to ISSUE and held through RUN
        if ((state_d == ISSUE) && (state_q != ISSUE)) begin
            pulse_num_d = chunk_of(remaining_d);
        end

        trigger_d = (state_d == ISSUE);
        done_d    = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            steps_done_q  <= '0;
            pulse_num_q   <= '0;
            pulse_width_q <= '0;
            setup_cnt_q   <= '0;
            trigger_q     <= 1'b0;
            dir_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            steps_done_q  <= steps_done_d;
            pulse_num_q   <= pulse_num_d;
            pulse_width_q <= pulse_width_d;
            setup_cnt_q   <= setup_cnt_d;
            trigger_q     <= trigger_d;
            dir_q         <= dir_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            abort_q       <= abort_d;
        end
    end

    assign pg_pulse_num   = pulse_num_q;
    assign pg_pulse_width = pulse_width_q;
    assign pg_trigger     = trigger_q;
    assign dir_out        = dir_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign steps_done     = steps_done_q;

endmodule

// File: tb/tb_step_move_ctrl.sv
// tb_step_move_ctrl
//   Bench for step_move_ctrl with a small PulseGen stand-in (one pulse per
//   en tick). Each move's expected bursts, final step count, DIR level and
//   pulse width are worked out from the command alone; a negedge monitor
//   holds the DUT to them.
module tb_step_move_ctrl;

    localparam int SB    = 16;
    localparam int PB    = 8;
    localparam int WB    = 8;
    localparam int DST   = 2;
    localparam int MAXC  = 255;
    localparam int BOUND = 4000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic [SB-1:0] steps = '0;
    logic          dir = 1'b0;
    logic [WB-1:0] pulse_width = '0;
    logic          abort = 1'b0;
    logic          pg_done;
    logic [PB-1:0] pg_pulse_num;
    logic [WB-1:0] pg_pulse_width;
    logic          pg_trigger;
    logic          dir_out;
    logic          busy;
    logic          done;
    logic [SB-1:0] steps_done;

    step_move_ctrl #(
        .STEPS_BITS(SB), .PULSE_NUM_BITS(PB), .PULSE_WIDTH_BITS(WB), .DIR_SETUP_TICKS(DST)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .steps(steps), .dir(dir),
        .pulse_width(pulse_width), .abort(abort), .pg_done(pg_done),
        .pg_pulse_num(pg_pulse_num), .pg_pulse_width(pg_pulse_width),
        .pg_trigger(pg_trigger), .dir_out(dir_out), .busy(busy), .done(done),
        .steps_done(steps_done)
    );

    always #5 clk = ~clk;

    int cmp_count = 0;
    int fail_count = 0;

    int cyc = 0;
    int en_ticks = 0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        en_ticks <= en_ticks + (en ? 1 : 0);
    end

    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            en = ((k % 3) == 0);
            k++;
        end
    end

    // PulseGen stand-in: accepts a trigger while idle, then one pulse per en
    int pg_left = 0;
    int pulse_total = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pg_done <= 1'b1;
            pg_left <= 0;
        end else if (pg_done) begin
            if (pg_trigger) begin
                pg_done <= 1'b0;
                pg_left <= int'(pg_pulse_num);
            end
        end else if (en) begin
            pulse_total <= pulse_total + 1;
            if (pg_left <= 1) pg_done <= 1'b1;
            pg_left <= pg_left - 1;
        end
    end

    // expectations for the move in progress
    int exp_bursts[$];
    int exp_total = 0;
    int exp_ntrig = 0;
    int exp_width = 0;
    bit exp_dir = 1'b0;
    bit model_dir = 1'b0;
    bit move_active = 1'b0;
    bit move_setup = 1'b0;
    bit first_trig_seen = 1'b0;
    int start_cyc = 0;
    int pulse_base = 0;
    int trig_base = 0;
    int trig_total = 0;
    int mark = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        cmp_count++;
        if (act != exp) begin
            fail_count++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pulse_num"}, pg_pulse_num, 0);
        chk({tag, "_pulse_width"}, pg_pulse_width, 0);
        chk({tag, "_trigger"}, pg_trigger, 0);
        chk({tag, "_dir_out"}, dir_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_steps_done"}, steps_done, 0);
    endtask

    // monitor
    initial begin
        bit trig_prev, done_prev, dir_prev;
        int b;
        trig_prev = 1'b0;
        done_prev = 1'b0;
        dir_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (dir_out != dir_prev) mark = en_ticks;
                if (pg_trigger) chk("trigger_num_nonzero", (pg_pulse_num != 0), 1);
                if (pg_trigger && !trig_prev) begin
                    trig_total++;
                    chk("trigger_expected", (move_active && exp_bursts.size() > 0), 1);
                    if (exp_bursts.size() > 0) begin
                        b = exp_bursts.pop_front();
                        chk("burst_len", pg_pulse_num, b);
                    end
                    if (move_active && !first_trig_seen) begin
                        first_trig_seen = 1'b1;
                        if (move_setup) chk("dir_setup_ticks", en_ticks - mark, DST);
                        else            chk("no_setup_latency", cyc - start_cyc, 1);
                    end
                end
                if (move_active && busy) begin
                    chk("busy_pulse_width", pg_pulse_width, exp_width);
                    chk("busy_dir_out", dir_out, exp_dir);
                end
                if (done) begin
                    chk("done_expected", move_active, 1);
                    if (move_active) begin
                        chk("done_steps_done", steps_done, exp_total);
                        chk("done_pulses", pulse_total - pulse_base, exp_total);
                        chk("done_bursts_left", exp_bursts.size(), 0);
                        chk("done_trig_count", trig_total - trig_base, exp_ntrig);
                        chk("done_busy", busy, 1);
                        move_active = 1'b0;
                    end
                end
                if (done_prev) begin
                    chk("done_one_cycle", done, 0);
                    chk("busy_after_done", busy, 0);
                end
            end
            trig_prev = pg_trigger;
            done_prev = done;
            dir_prev  = dir_out;
        end
    end

    // abort_mode: 0 none, 1 during first burst, 2 during SETUP, 3 reset mid-RUN
    task automatic do_move(input int st, input bit d, input int w, input int abort_mode,
                           input bit spurious);
        int rem, c, n;
        bit sent;
        exp_bursts.delete();
        rem = st;
        exp_total = 0;
        while (rem > 0 && abort_mode != 2) begin
            c = (rem > MAXC) ? MAXC : rem;
            exp_bursts.push_back(c);
            exp_total += c;
            rem -= c;
            if (abort_mode == 1) break;
        end
        exp_ntrig  = exp_bursts.size();
        move_setup = (st != 0) && (d != model_dir);
        if (st != 0) model_dir = d;
        exp_dir   = model_dir;
        exp_width = w;

        @(negedge clk);
        steps = SB'(st);
        dir = d;
        pulse_width = WB'(w);
        start = 1'b1;
        start_cyc = cyc;
        pulse_base = pulse_total;
        trig_base = trig_total;
        first_trig_seen = 1'b0;
        move_active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sent = (abort_mode != 1);
        if (abort_mode == 2) abort = 1'b1;
        n = 0;
        while (!done && n < BOUND) begin
            @(negedge clk);
            n++;
            abort = 1'b0;
            if (!sent && !pg_done) begin
                abort = 1'b1;
                sent = 1'b1;
            end
            if (spurious && n == 4) begin
                start = 1'b1;
                steps = SB'(3);
                dir = ~d;
                pulse_width = WB'(w + 7);
            end else begin
                start = 1'b0;
            end
            if (abort_mode == 3 && !pg_done && !pg_trigger) begin
                #2;
                reset = 1'b0;
                move_active = 1'b0;
                exp_bursts.delete();
                model_dir = 1'b0;
                #1;
                check_reset_outputs("reset_mid_run");
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
                break;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (abort_mode != 3) begin
            chk("move_completes", done, 1);
            if (st == 0) chk("zero_move_latency", (n <= 1), 1);
            if (!done) move_active = 1'b0;
        end else begin
            chk("reset_reached", reset, 1);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        do_move(5, 1'b0, 2, 0, 1'b0);
        chk("t1_steps_done", steps_done, 5);
        chk("t1_triggers", trig_total - trig_base, 1);

        do_move(600, 1'b1, 3, 0, 1'b0);
        chk("t2_steps_done", steps_done, 600);
        chk("t2_triggers", trig_total - trig_base, 3);
        chk("t2_dir_out", dir_out, 1);

        do_move(0, 1'b0, 4, 0, 1'b0);
        chk("t3_steps_done", steps_done, 0);
        chk("t3_triggers", trig_total - trig_base, 0);
        chk("t3_dir_out", dir_out, 1);

        do_move(600, 1'b1, 6, 1, 1'b0);
        chk("t4_steps_done", steps_done, 255);
        chk("t4_pulses", pulse_total - pulse_base, 255);

        do_move(10, 1'b1, 5, 0, 1'b1);
        chk("t5_steps_done", steps_done, 10);

        do_move(20, 1'b0, 9, 2, 1'b0);
        chk("setup_abort_steps_done", steps_done, 0);
        chk("setup_abort_triggers", trig_total - trig_base, 0);

        do_move(600, 1'b1, 3, 3, 1'b0);
        check_reset_outputs("after_reset");

        do_move(4, 1'b1, 2, 0, 1'b0);
        chk("t6_steps_done", steps_done, 4);

        do_move(255, 1'b1, 1, 0, 1'b0);
        chk("max_burst_triggers", trig_total - trig_base, 1);

        do_move(256, 1'b1, 8, 0, 1'b0);
        chk("max_plus1_steps_done", steps_done, 256);
        chk("max_plus1_triggers", trig_total - trig_base, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
